// File: rtl/sdp_y_mul_core_triosy_pkg.sv
// Shared constants for the SDP Y mul core triosy wait datapath.
// Default bank sizing and named resource channel indices.
package sdp_y_mul_core_triosy_pkg;

   localparam int NUM_RSC_DEF  = 4;
   localparam int CNT_W_DEF    = 4;

   localparam int RSC_TRUNCATE = 0;
   localparam int RSC_SCALE    = 1;
   localparam int RSC_SHIFT    = 2;
   localparam int RSC_OFFSET   = 3;

endpackage

// File: rtl/sdp_y_mul_core_triosy_wait_dp_ch.sv
// One triosy wait datapath channel: sticky bcwt, lz pulse, overrun, counter.
// Ports: clk/rstn, biwt, bdwt, cnt_clr in; lz, bcwt, ovf, hs_cnt out.
module sdp_y_mul_core_triosy_wait_dp_ch
   import sdp_y_mul_core_triosy_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             biwt,
   input  logic             bdwt,
   input  logic             cnt_clr,
   output logic             lz,
   output logic             bcwt,
   output logic             ovf,
   output logic [CNT_W-1:0] hs_cnt
);

   logic ev;
   logic orun;
   logic sat;

   // Only a fresh completion counts; a repeat biwt on an
   // undrained completion is an overrun instead.
   assign ev   = biwt & ~bcwt;
   assign orun = biwt & bcwt & ~bdwt;
   assign sat  = &hs_cnt;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         lz     <= 1'b0;
         bcwt   <= 1'b0;
         ovf    <= 1'b0;
         hs_cnt <= '0;
      end else begin
         lz   <= ev;
         bcwt <= ~bdwt & (bcwt | biwt);
         // A new overrun wins over a clear in the same edge.
         if (orun)
            ovf <= 1'b1;
         else if (cnt_clr)
            ovf <= 1'b0;
         if (cnt_clr)
            hs_cnt <= CNT_W'(ev);
         else if (ev && !sat)
            hs_cnt <= hs_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sdp_y_mul_core_cfg_triosy_wait_dp_bank.sv
// Bank of triosy wait datapath channels plus the all_done qualifier.
// Ports: clk/rstn, core_wen, biwt, bdwt, cnt_clr in; lz, bcwt, all_done, ovf, hs_cnt out.
module sdp_y_mul_core_cfg_triosy_wait_dp_bank
   import sdp_y_mul_core_triosy_pkg::*;
#(
   parameter int NUM_RSC = NUM_RSC_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rstn,
   input  logic                     core_wen,
   input  logic [NUM_RSC-1:0]       biwt,
   input  logic [NUM_RSC-1:0]       bdwt,
   input  logic                     cnt_clr,
   output logic [NUM_RSC-1:0]       lz,
   output logic [NUM_RSC-1:0]       bcwt,
   output logic                     all_done,
   output logic [NUM_RSC-1:0]       ovf,
   output logic [NUM_RSC*CNT_W-1:0] hs_cnt
);

   for (genvar i = 0; i < NUM_RSC; i++) begin : g_ch
      sdp_y_mul_core_triosy_wait_dp_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .nvdla_core_clk  (nvdla_core_clk),
         .nvdla_core_rstn (nvdla_core_rstn),
         .biwt            (biwt[i]),
         .bdwt            (bdwt[i]),
         .cnt_clr         (cnt_clr),
         .lz              (lz[i]),
         .bcwt            (bcwt[i]),
         .ovf             (ovf[i]),
         .hs_cnt          (hs_cnt[i*CNT_W +: CNT_W])
      );
   end

   // A channel completing this cycle counts as done already.
   assign all_done = core_wen & (&(bcwt | biwt));

endmodule

// File: tb/tb_sdp_y_mul_core_cfg_triosy_wait_dp_bank.sv
// Scoreboard bench for the triosy wait datapath bank.
// Drives on negedge, compares registered state just after posedge.
module tb_sdp_y_mul_core_cfg_triosy_wait_dp_bank;

   typedef struct packed {
      logic [3:0]  lz;
      logic [3:0]  bcwt;
      logic [3:0]  ovf;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        core_wen;
   logic [3:0]  biwt;
   logic [3:0]  bdwt;
   logic        cnt_clr;
   logic [3:0]  lz;
   logic [3:0]  bcwt;
   logic        all_done;
   logic [3:0]  ovf;
   logic [15:0] hs_cnt;

   int   n_run  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   logic [3:0] m_bcwt;
   logic [3:0] m_ovf;
   logic [3:0] m_lz;
   int         m_cnt[4];
   logic       ad_seen;

   sdp_y_mul_core_cfg_triosy_wait_dp_bank dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .core_wen        (core_wen),
      .biwt            (biwt),
      .bdwt            (bdwt),
      .cnt_clr         (cnt_clr),
      .lz              (lz),
      .bcwt            (bcwt),
      .all_done        (all_done),
      .ovf             (ovf),
      .hs_cnt          (hs_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pack_cnt();
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 4; i++)
         p[i*4 +: 4] = 4'(m_cnt[i]);
      return p;
   endfunction

   task automatic model_rst();
      m_bcwt = '0;
      m_ovf  = '0;
      m_lz   = '0;
      for (int i = 0; i < 4; i++)
         m_cnt[i] = 0;
   endtask

   task automatic step(input logic [3:0] bi, input logic [3:0] bd,
                       input logic cw, input logic clr);
      exp_t e;
      exp_t g;
      logic ev;
      logic ov;
      @(negedge clk);
      biwt     = bi;
      bdwt     = bd;
      core_wen = cw;
      cnt_clr  = clr;
      #1;
      ad_seen = all_done;
      check("all_done", all_done, cw & (&(m_bcwt | bi)));
      for (int i = 0; i < 4; i++) begin
         ev = bi[i] && !m_bcwt[i];
         ov = bi[i] && m_bcwt[i] && !bd[i];
         m_lz[i] = ev;
         if (bd[i])
            m_bcwt[i] = 1'b0;
         else if (bi[i])
            m_bcwt[i] = 1'b1;
         if (ov)
            m_ovf[i] = 1'b1;
         else if (clr)
            m_ovf[i] = 1'b0;
         if (clr)
            m_cnt[i] = ev ? 1 : 0;
         else if (ev && m_cnt[i] < 15)
            m_cnt[i]++;
      end
      e.lz   = m_lz;
      e.bcwt = m_bcwt;
      e.ovf  = m_ovf;
      e.cnt  = pack_cnt();
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check("lz", lz, g.lz);
      check("bcwt", bcwt, g.bcwt);
      check("ovf", ovf, g.ovf);
      check("hs_cnt", hs_cnt, g.cnt);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(4'b0, 4'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rstn     = 1'b0;
      core_wen = 1'b0;
      biwt     = '0;
      bdwt     = '0;
      cnt_clr  = 1'b0;
      model_rst();
      #12;
      check("rst lz", lz, 0);
      check("rst bcwt", bcwt, 0);
      check("rst ovf", ovf, 0);
      check("rst cnt", hs_cnt, 0);
      @(negedge clk);
      rstn = 1'b1;

      // reset in the middle of a handshake
      step(4'b0001, 4'b0, 1'b0, 1'b0);
      check("mid bcwt pre", bcwt, 4'b0001);
      #2;
      rstn = 1'b0;
      #1;
      model_rst();
      check("mid rst bcwt", bcwt, 0);
      check("mid rst lz", lz, 0);
      check("mid rst ovf", ovf, 0);
      check("mid rst cnt", hs_cnt, 0);
      @(negedge clk);
      rstn = 1'b1;
      biwt = '0;
      idle(2);
      check("post rst lz", lz, 0);

      // single handshake on channel 0
      step(4'b0001, 4'b0, 1'b0, 1'b0);
      check("single lz", lz, 4'b0001);
      idle(1);
      check("single lz off", lz, 0);
      idle(3);
      check("single bcwt", bcwt, 4'b0001);
      step(4'b0, 4'b0001, 1'b0, 1'b0);
      check("single drain", bcwt, 0);
      check("single cnt", hs_cnt[3:0], 1);

      // back-to-back drained handshakes on channel 1
      for (int k = 0; k < 3; k++) begin
         step(4'b0010, 4'b0010, 1'b0, 1'b0);
         check("b2b lz", lz[1], 1);
      end
      check("b2b bcwt", bcwt[1], 0);
      check("b2b ovf", ovf[1], 0);
      check("b2b cnt", hs_cnt[7:4], 3);

      // overrun on channel 2
      step(4'b0100, 4'b0, 1'b0, 1'b0);
      idle(2);
      step(4'b0100, 4'b0, 1'b0, 1'b0);
      check("orun lz", lz[2], 0);
      check("orun ovf", ovf[2], 1);
      idle(2);
      check("orun cnt", hs_cnt[11:8], 1);
      step(4'b0, 4'b0, 1'b0, 1'b1);
      check("clr ovf", ovf[2], 0);
      check("clr cnt", hs_cnt[11:8], 0);

      // clear coinciding with a fresh overrun keeps ovf set
      step(4'b0100, 4'b0, 1'b0, 1'b0);
      step(4'b0100, 4'b0, 1'b0, 1'b1);
      check("clr+orun ovf", ovf[2], 1);
      step(4'b0, 4'b0100, 1'b0, 1'b1);

      // saturation on channel 3
      for (int k = 0; k < 20; k++)
         step(4'b1000, 4'b1000, 1'b0, 1'b0);
      check("sat cnt", hs_cnt[15:12], 15);
      step(4'b1000, 4'b1000, 1'b0, 1'b1);
      check("clr+ev cnt", hs_cnt[15:12], 1);

      // all_done qualifier
      step(4'b0, 4'b1111, 1'b0, 1'b0);
      step(4'b0111, 4'b0, 1'b0, 1'b0);
      step(4'b1000, 4'b0, 1'b1, 1'b0);
      check("done hi", ad_seen, 1);
      step(4'b0, 4'b1000, 1'b0, 1'b0);
      step(4'b1000, 4'b0, 1'b0, 1'b0);
      check("done no wen", ad_seen, 0);
      step(4'b0, 4'b1000, 1'b0, 1'b0);
      step(4'b0, 4'b0, 1'b1, 1'b0);
      check("done no biwt", ad_seen, 0);

      // random traffic through the scoreboard
      for (int k = 0; k < 200; k++)
         step(4'($urandom), 4'($urandom), 1'($urandom),
              ($urandom_range(0, 15) == 0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/sdp_y_mul_core_cfg_triosy_wait_dp_bank.md
Name: sdp_y_mul_core_cfg_triosy_wait_dp_bank

Overview:
- Sequential datapath that sits directly downstream of the per-resource triosy wait_ctrl stages in the SDP Y mul core.
- Consumes each channel's biwt/bdwt pair and holds the sticky completion flag (bcwt) until the core drains it.
- Generates the registered triosy lz pulse per resource (cfg_truncate, cfg_scale, cfg_shift, ...).
- Keeps per-channel saturating handshake counters and sticky overrun flags for debug and visibility.

Parameters:
- NUM_RSC, 4: number of triosy resource channels; bit 0 is cfg_truncate.
- CNT_W, 4: width of each per-channel handshake counter.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- core_wen  in  1  core write enable, used only for the all_done qualifier
- biwt  in  NUM_RSC  per-channel "handshake now" from wait_ctrl (~core_wten & iswt0)
- bdwt  in  NUM_RSC  per-channel "drain" from wait_ctrl (oswt & core_wen)
- cnt_clr  in  1  synchronous clear of all counters and overrun flags
- lz  out  NUM_RSC  registered triosy valid pulse per channel
- bcwt  out  NUM_RSC  sticky completion flag per channel
- all_done  out  1  every channel is complete or completing this cycle, qualified by core_wen
- ovf  out  NUM_RSC  sticky overrun per channel
- hs_cnt  out  NUM_RSC*CNT_W  per-channel handshake counters; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset is asynchronous, active-low, on nvdla_core_clk. Asserting it clears lz, bcwt, ovf and hs_cnt to 0. Deassertion is synchronous to the clock edge.
- Reset asserted mid-handshake drops any pending bcwt and gives no lz pulse. The first edge after release behaves as if from idle.
- bcwt register, per channel: bcwt_next = ~bdwt & (bcwt | biwt).
  - bdwt has priority: biwt and bdwt in the same cycle leaves bcwt at 0.
  - bcwt holds at 1 while neither input is active.
- Handshake event: ev = biwt & ~bcwt. Only a new completion counts; biwt while bcwt is already 1 is not an event.
- lz: lz <= ev. This is a single-cycle pulse with 1-cycle latency from biwt.
  - Back-to-back biwt with bdwt draining every cycle gives consecutive lz pulses.
  - biwt held high without a drain gives exactly one pulse.
- ovf: set when biwt & bcwt & ~bdwt (a re-handshake while a completion is still undrained). Sticky until cnt_clr or reset.
- hs_cnt[i] update:
  - On ev, increment, saturating at 2^CNT_W-1. No wrap.
  - cnt_clr alone: 0.
  - cnt_clr together with ev: 1.
  - cnt_clr clears ovf in the same edge. If an overrun occurs in that same cycle, ovf ends at 1 (the set wins).
- all_done: combinational = core_wen & (&(bcwt | biwt)). No register, zero latency.
- Channels are fully independent. Simultaneous events on several channels each update their own state in the same cycle.
- No X propagation: all state bits are reset. With NUM_RSC=1 the block still builds, and all_done reduces to core_wen & (bcwt|biwt).

Decomposition:
- Shared package sdp_y_mul_core_triosy_pkg holds the default NUM_RSC/CNT_W constants and named channel index constants (RSC_TRUNCATE=0, RSC_SCALE=1, RSC_SHIFT=2, RSC_OFFSET=3).
- One sub-module, sdp_y_mul_core_triosy_wait_dp_ch: a single channel holding bcwt, lz, ovf and its counter. It is instantiated NUM_RSC times in a generate loop.
- all_done and the packing of hs_cnt live in the top.

Test Plan:
- Reset mid-op: drive biwt[0]=1 for 1 cycle, then pull rstn low asynchronously between edges -> bcwt, lz, ovf and hs_cnt read 0 immediately. After release with idle inputs, all stay 0.
- Single handshake: biwt[0]=1 at cycle 0 and bdwt=0 thereafter -> lz[0]=1 only in cycle 1; bcwt[0]=1 from cycle 1 on; hs_cnt[0]=1. Then bdwt[0]=1 at cycle 5 -> bcwt[0]=0 at cycle 6.
- Simultaneous biwt & bdwt on channel 1 for 3 cycles with bcwt=0 -> lz[1] pulses in 3 consecutive cycles, bcwt[1] stays 0, hs_cnt[1]=3, ovf[1]=0.
- Overrun: biwt[2]=1 at cycles 0 and 3 with no bdwt -> a single lz[2] pulse, ovf[2]=1 from cycle 4, hs_cnt[2]=1. cnt_clr at cycle 6 -> ovf[2]=0 and hs_cnt[2]=0 at cycle 7.
- Saturation: CNT_W=4, 20 drained handshakes on channel 3 -> hs_cnt[3]=15 and holds. cnt_clr coincident with an event -> hs_cnt[3]=1.
- all_done: bcwt = 4'b0111, biwt[3]=1, core_wen=1 -> all_done=1 in the same cycle. Same stimulus with core_wen=0, or with biwt[3]=0 -> all_done=0.
